lcd_pixel_feeder: RTL and testbench
===================================

Name: lcd_pixel_feeder

Overview:
- Upstream word source for the LCD write-strobe controller: on `start` it produces one complete frame as a stream of 16-bit words on `lcd_db`/`lcd_rs`.
- Frame content: 11-word window-setup command list (0x2A/0x2B/0x2C, ILI93xx-style 8080 bus), then H_RES*V_RES RGB565 pixels from a built-in pattern generator.
- Drives the controller's `en` and `data_stop`; advances one word per `addr_en` pulse.
- Used for panel bring-up and as the default frame source before a frame buffer exists.

Parameters:
- H_RES, 240, pixels per line (multiple of 8, >= 8).
- V_RES, 320, lines per frame (>= 1).
- DW, 16, LCD data bus width (fixed at 16; RGB565).

Ports:
- clk  in  1  system clock; same clock as the write-strobe controller.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to send a frame; ignored while busy=1.
- mode  in  2  pattern select, latched on accepted start: 0 solid fill_color, 1 eight vertical colour bars, 2 16x16 checkerboard white/black, 3 solid black.
- fill_color  in  16  RGB565 colour for mode 0; latched on accepted start.
- addr_en  in  1  word-consumed pulse from the write-strobe controller (high during its ADDR cycle).
- wr_en  out  1  to the controller's `en`; high while the frame is in progress.
- data_stop  out  1  to the controller's `data_stop`; high while the presented word is the frame's last word.
- lcd_rs  out  1  0 = command word, 1 = data word.
- lcd_db  out  16  current word; held stable until consumed.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last word is consumed.

Behaviour:
- Reset values (all outputs registered): wr_en=0, data_stop=0, lcd_rs=1, lcd_db=0x0000, busy=0, done=0; state=IDLE; all counters 0.
- States: IDLE, CMD, PIX.
- IDLE -> CMD on start:
  - latch mode and fill_color;
  - present word 0;
  - set busy=1 and wr_en=1 in the next cycle.
- CMD word list, in index order 0..10 (rs shown in brackets):
  - index 0: 0x002A [rs=0]
  - index 1: 0x0000 [rs=1]
  - index 2: 0x0000 [rs=1]
  - index 3: (H_RES-1)>>8 [rs=1]
  - index 4: (H_RES-1)&0xFF [rs=1]
  - index 5: 0x002B [rs=0]
  - index 6: 0x0000 [rs=1]
  - index 7: 0x0000 [rs=1]
  - index 8: (V_RES-1)>>8 [rs=1]
  - index 9: (V_RES-1)&0xFF [rs=1]
  - index 10: 0x002C [rs=0]
- Word advance:
  - On addr_en=1, the next word appears on lcd_db/lcd_rs in the following cycle.
  - The controller's 1-cycle WAIT provides setup before its WR_L.
  - addr_en at index 10 -> PIX, x=0, y=0.
- PIX:
  - lcd_rs=1.
  - Each addr_en increments x; when x reaches H_RES-1 it wraps to 0 and y increments.
  - Pixel word is registered from next-(x,y), so there is no combinational path from addr_en to lcd_db.
- Patterns:
  - Colour bars: bar width H_RES/8, tracked with a bar counter (no divider). Bar colours 0..7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Checker: x[4]^y[4] ? 0x0000 : 0xFFFF.
- data_stop:
  - Combinationally equal to (state==PIX && x==H_RES-1 && y==V_RES-1).
  - Must be valid in the same cycle as addr_en for the last word.
- Frame end (addr_en while data_stop=1):
  - Next cycle: wr_en=0, busy=0, data_stop=0, state=IDLE, done=1 for one cycle.
  - wr_en is therefore low in the controller's IDLE cycle, so no spurious restart.
- Simultaneous start and final addr_en: start is ignored (busy still 1). A new start is accepted from the done cycle onward.
- addr_en while IDLE: ignored.
- Reset mid-frame: immediate return to reset values. The controller shares the same reset source (inverted to its rstn), so both restart cleanly. The panel receives a partial frame; the next frame rewrites the window.
- Counter widths: $clog2(H_RES), $clog2(V_RES), 4-bit command index.

Decomposition:
- Shared package lcd_pkg:
  - command opcodes CMD_CASET=0x2A, CMD_PASET=0x2B, CMD_RAMWR=0x2C;
  - RGB565 colour constants;
  - mode encodings.
- One sub-module, lcd_pattern_gen: (mode, colour, x, y, bar index) -> RGB565, combinational. Feeder registers its output.

Test Plan (H_RES=16, V_RES=4, feeder coupled to the write-strobe controller model):
- Mode 0, fill_color=0xF800, single start -> exactly 75 WR_L pulses:
  - words 0..10 = 002A,0000,0000,0000,000F,002B,0000,0000,0000,0003,002C with rs=0 only at indices 0,5,10;
  - then 64 words of F800 with rs=1;
  - done one cycle after the 75th addr_en; wr_en low in the controller's IDLE cycle.
- Mode 1 -> pixel x=0..1 = FFFF, x=2..3 = FFE0, …, x=14..15 = 0000, repeated on every line.
- Mode 2 with H_RES=32, V_RES=32 -> pixel (0,0)=FFFF, (16,0)=0000, (0,16)=0000, (16,16)=FFFF.
- start pulsed mid-frame and coincident with the final addr_en -> no extra words; the frame word count stays 75.
- rst asserted at pixel 20 -> all outputs at reset values next cycle; a following start produces a full 75-word frame beginning with 0x002A.
- Back-to-back: start issued in the done cycle -> second frame begins; the controller returns from IDLE to WAIT with no lost or duplicated words.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame feeder: opcodes, RGB565 palette,
// pattern modes and the window-setup command list.
package lcd_pkg;

  localparam logic [15:0] CMD_CASET = 16'h002A;
  localparam logic [15:0] CMD_PASET = 16'h002B;
  localparam logic [15:0] CMD_RAMWR = 16'h002C;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  localparam logic [3:0] CMD_LAST = 4'd10;

  typedef enum logic [1:0] {
    MODE_FILL    = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BLACK   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_PIX  = 2'd2
  } state_e;

  typedef struct packed {
    logic        rs;
    logic [15:0] db;
  } lcd_word_t;

  // Window-setup list: CASET 0..h_last, PASET 0..v_last, then RAMWR.
  function automatic lcd_word_t cmd_word(input logic [3:0]  idx,
                                         input logic [15:0] h_last,
                                         input logic [15:0] v_last);
    lcd_word_t w;
    w.rs = 1'b1;
    w.db = 16'h0000;
    case (idx)
      4'd0:    begin w.rs = 1'b0; w.db = CMD_CASET; end
      4'd3:    w.db = {8'h00, h_last[15:8]};
      4'd4:    w.db = {8'h00, h_last[7:0]};
      4'd5:    begin w.rs = 1'b0; w.db = CMD_PASET; end
      4'd8:    w.db = {8'h00, v_last[15:8]};
      4'd9:    w.db = {8'h00, v_last[7:0]};
      4'd10:   begin w.rs = 1'b0; w.db = CMD_RAMWR; end
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] bar_color(input logic [2:0] bar);
    logic [15:0] c;
    case (bar)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Combinational RGB565 test-pattern source; the feeder registers its output.
module lcd_pattern_gen
  import lcd_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [15:0] color,
  input  logic        x4,
  input  logic        y4,
  input  logic [2:0]  bar,
  output logic [15:0] pixel_c
);

  always_comb begin
    pixel_c = RGB_BLACK;
    case (mode_e'(mode))
      MODE_FILL:    pixel_c = color;
      MODE_BARS:    pixel_c = bar_color(bar);
      MODE_CHECKER: pixel_c = (x4 ^ y4) ? RGB_BLACK : RGB_WHITE;
      default:      pixel_c = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/lcd_pixel_feeder.sv
// Frame word source for the LCD write-strobe controller: window-setup
// commands followed by H_RES*V_RES pattern pixels, one word per addr_en.
module lcd_pixel_feeder
  import lcd_pkg::*;
#(
  parameter int unsigned H_RES = 240,
  parameter int unsigned V_RES = 320,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] fill_color,
  input  logic          addr_en,
  output logic          wr_en,
  output logic          data_stop,
  output logic          lcd_rs,
  output logic [DW-1:0] lcd_db,
  output logic          busy,
  output logic          done
);

  localparam int unsigned XW  = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW  = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned BW  = H_RES / 8;
  localparam int unsigned BCW = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [XW-1:0]  X_LAST  = XW'(H_RES - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(V_RES - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BW - 1);
  localparam logic [15:0]    H_LAST  = 16'(H_RES - 1);
  localparam logic [15:0]    V_LAST  = 16'(V_RES - 1);

  state_e         state;
  logic [3:0]     cmd_idx;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [2:0]     bar;
  logic [BCW-1:0] bcnt;
  logic [1:0]     mode_q;
  logic [DW-1:0]  color_q;

  logic [XW-1:0]  nx;
  logic [YW-1:0]  ny;
  logic [2:0]     nbar;
  logic [BCW-1:0] nbcnt;
  logic [3:0]     cmd_sel;
  lcd_word_t      cmd_c;
  logic [15:0]    pixel_c;
  logic           x4;
  logic           y4;

  // Coordinates of the word after the current one; (0,0) when entering PIX.
  always_comb begin
    nx    = '0;
    ny    = '0;
    nbar  = '0;
    nbcnt = '0;
    if (state == ST_PIX) begin
      if (x == X_LAST) begin
        ny = y + 1'b1;
      end else begin
        nx = x + 1'b1;
        ny = y;
        if (bcnt == BC_LAST) begin
          nbar = bar + 3'd1;
        end else begin
          nbar  = bar;
          nbcnt = bcnt + 1'b1;
        end
      end
    end
  end

  if (XW > 4) begin : g_x4
    assign x4 = nx[4];
  end else begin : g_x4_zero
    assign x4 = 1'b0;
  end

  if (YW > 4) begin : g_y4
    assign y4 = ny[4];
  end else begin : g_y4_zero
    assign y4 = 1'b0;
  end

  assign cmd_sel = (state == ST_CMD) ? cmd_idx + 4'd1 : 4'd0;
  assign cmd_c   = cmd_word(cmd_sel, H_LAST, V_LAST);

  lcd_pattern_gen u_pattern (
    .mode    (mode_q),
    .color   (color_q),
    .x4      (x4),
    .y4      (y4),
    .bar     (nbar),
    .pixel_c (pixel_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_idx   <= '0;
      x         <= '0;
      y         <= '0;
      bar       <= '0;
      bcnt      <= '0;
      mode_q    <= '0;
      color_q   <= '0;
      wr_en     <= 1'b0;
      data_stop <= 1'b0;
      lcd_rs    <= 1'b1;
      lcd_db    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            color_q <= fill_color;
            cmd_idx <= '0;
            lcd_rs  <= cmd_c.rs;
            lcd_db  <= cmd_c.db;
            busy    <= 1'b1;
            wr_en   <= 1'b1;
            state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (addr_en) begin
            if (cmd_idx == CMD_LAST) begin
              x         <= nx;
              y         <= ny;
              bar       <= nbar;
              bcnt      <= nbcnt;
              lcd_rs    <= 1'b1;
              lcd_db    <= pixel_c;
              data_stop <= (nx == X_LAST) && (ny == Y_LAST);
              state     <= ST_PIX;
            end else begin
              cmd_idx <= cmd_sel;
              lcd_rs  <= cmd_c.rs;
              lcd_db  <= cmd_c.db;
            end
          end
        end
        ST_PIX: begin
          if (addr_en) begin
            // Last word consumed: drop wr_en so the controller parks in IDLE.
            if (data_stop) begin
              wr_en     <= 1'b0;
              busy      <= 1'b0;
              data_stop <= 1'b0;
              done      <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              x         <= nx;
              y         <= ny;
              bar       <= nbar;
              bcnt      <= nbcnt;
              lcd_db    <= pixel_c;
              data_stop <= (nx == X_LAST) && (ny == Y_LAST);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Randomized bench: two feeders (16x4 and 32x32) driven by a write-strobe
// controller model, compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_lcd_pixel_feeder;

  localparam int H0 = 16;
  localparam int V0 = 4;
  localparam int H1 = 32;
  localparam int V1 = 32;

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_WRL, C_ADDR} ctl_e;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start;
  logic [1:0]  addr_en;
  logic [1:0]  mode [2];
  logic [15:0] fill [2];
  wire  [1:0]  wr_en;
  wire  [1:0]  data_stop;
  wire  [1:0]  lcd_rs;
  wire  [1:0]  busy;
  wire  [1:0]  done;
  wire  [15:0] lcd_db [2];

  int          n_vec = 0;
  int          n_bad = 0;
  int          m_widx [2];
  int          cap_idx [2];
  int          m_mode [2];
  logic [15:0] m_fill [2];
  bit          m_busy [2];
  bit          m_done [2];
  bit          coin [2];
  bit          st_req [2];
  bit          rst_req;
  bit          exp_rst;
  ctl_e        ctl [2];
  logic [15:0] bars [8];

  always #5 clk = ~clk;

  lcd_pixel_feeder #(.H_RES(H0), .V_RES(V0), .DW(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .mode(mode[0]), .fill_color(fill[0]),
    .addr_en(addr_en[0]), .wr_en(wr_en[0]), .data_stop(data_stop[0]),
    .lcd_rs(lcd_rs[0]), .lcd_db(lcd_db[0]), .busy(busy[0]), .done(done[0])
  );

  lcd_pixel_feeder #(.H_RES(H1), .V_RES(V1), .DW(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .mode(mode[1]), .fill_color(fill[1]),
    .addr_en(addr_en[1]), .wr_en(wr_en[1]), .data_stop(data_stop[1]),
    .lcd_rs(lcd_rs[1]), .lcd_db(lcd_db[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int hres(int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int vres(int i);
    return (i == 0) ? V0 : V1;
  endfunction

  function automatic int nwords(int i);
    return 11 + hres(i) * vres(i);
  endfunction

  // Expected {rs, db} of word idx of a frame.
  function automatic logic [16:0] ref_word(int i, int idx, int md, logic [15:0] fl);
    int h;
    int v;
    int p;
    int x;
    int y;
    h = hres(i);
    v = vres(i);
    case (idx)
      0:          return {1'b0, 16'h002A};
      1, 2, 6, 7: return {1'b1, 16'h0000};
      3:          return {1'b1, 16'((h - 1) / 256)};
      4:          return {1'b1, 16'((h - 1) % 256)};
      5:          return {1'b0, 16'h002B};
      8:          return {1'b1, 16'((v - 1) / 256)};
      9:          return {1'b1, 16'((v - 1) % 256)};
      10:         return {1'b0, 16'h002C};
      default:    ;
    endcase
    p = idx - 11;
    x = p % h;
    y = p / h;
    case (md)
      0:       return {1'b1, fl};
      1:       return {1'b1, bars[x / (h / 8)]};
      2:       return {1'b1, (((x / 16) + (y / 16)) % 2 == 1) ? 16'h0000 : 16'hFFFF};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs, run the controller model, drive inputs, step the model.
  task automatic tick();
    bit ae;
    bit st;
    bit fin;
    bit poke;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("busy", 32'(busy[i]), 32'(m_busy[i]));
      check("wr_en", 32'(wr_en[i]), 32'(m_busy[i]));
      check("done", 32'(done[i]), 32'(m_done[i]));
      if (m_busy[i]) begin
        check("word", 32'({lcd_rs[i], lcd_db[i]}), 32'(ref_word(i, m_widx[i], m_mode[i], m_fill[i])));
        check("data_stop", 32'(data_stop[i]), 32'(m_widx[i] == nwords(i) - 1));
      end else begin
        check("data_stop_idle", 32'(data_stop[i]), 32'd0);
      end
      if (exp_rst) begin
        check("rst_db", 32'(lcd_db[i]), 32'h0);
        check("rst_rs", 32'(lcd_rs[i]), 32'd1);
      end
      if (ctl[i] == C_WRL) begin
        check("wr_capture", 32'({lcd_rs[i], lcd_db[i]}), 32'(ref_word(i, cap_idx[i], m_mode[i], m_fill[i])));
        cap_idx[i]++;
      end
      if (done[i]) begin
        check("frame_len", 32'(cap_idx[i]), 32'(nwords(i)));
        cap_idx[i] = 0;
      end

      ae   = (ctl[i] == C_ADDR);
      poke = !ae && !m_busy[i] && (ctl[i] == C_IDLE) && ($urandom_range(0, 3) == 0);
      st   = st_req[i] || (coin[i] && ae && m_busy[i] && m_widx[i] == nwords(i) - 1);
      st_req[i] = 1'b0;

      case (ctl[i])
        C_IDLE:  ctl[i] = wr_en[i] ? C_WAIT : C_IDLE;
        C_WAIT:  ctl[i] = C_WRL;
        C_WRL:   ctl[i] = C_ADDR;
        default: ctl[i] = data_stop[i] ? C_IDLE : C_WAIT;
      endcase

      addr_en[i] = ae | poke;
      start[i]   = st && !rst_req;

      fin = m_busy[i] && ae && (m_widx[i] == nwords(i) - 1);
      if (m_busy[i]) begin
        if (ae) begin
          if (fin) m_busy[i] = 1'b0;
          else     m_widx[i]++;
        end
      end else if (start[i]) begin
        m_busy[i] = 1'b1;
        m_widx[i] = 0;
        m_mode[i] = int'(mode[i]);
        m_fill[i] = fill[i];
      end
      m_done[i] = fin;
    end
    exp_rst = 1'b0;
    rst     = rst_req;
    if (rst_req) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  = 1'b0;
        m_done[i]  = 1'b0;
        m_widx[i]  = 0;
        cap_idx[i] = 0;
        ctl[i]     = C_IDLE;
      end
      exp_rst = 1'b1;
      rst_req = 1'b0;
    end
  endtask

  task automatic run_frame(input int i, input int md, input logic [15:0] fl, input bit noise);
    int n;
    n = 0;
    mode[i]   = 2'(md);
    fill[i]   = fl;
    st_req[i] = 1'b1;
    coin[i]   = noise;
    do begin
      tick();
      n++;
      if (noise && m_busy[i] && !start[i]) begin
        mode[i] = 2'($urandom_range(0, 3));
        fill[i] = 16'($urandom);
        if ($urandom_range(0, 30) == 0) st_req[i] = 1'b1;
      end
    end while (!m_done[i] && n < 20000);
    if (!m_done[i]) check("frame_timeout", 32'(m_done[i]), 32'd1);
    coin[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    rst     = 1'b1;
    start   = '0;
    addr_en = '0;
    rst_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = '0; fill[i] = '0; m_widx[i] = 0; cap_idx[i] = 0; m_mode[i] = 0;
      m_fill[i] = '0; m_busy[i] = 1'b0; m_done[i] = 1'b0; coin[i] = 1'b0;
      st_req[i] = 1'b0; ctl[i] = C_IDLE;
    end
    repeat (2) @(posedge clk);
    exp_rst = 1'b1;
    tick();
    idle(3);

    run_frame(0, 0, 16'hF800, 1'b0);
    idle(2);
    run_frame(0, 1, 16'($urandom), 1'b0);
    idle(2);
    run_frame(1, 2, 16'($urandom), 1'b0);
    idle(2);

    for (int k = 0; k < 6; k++) begin
      idle(int'($urandom_range(0, 3)));
      run_frame(0, int'($urandom_range(0, 3)), 16'($urandom), 1'b1);
    end

    // Reset while pixel 20 is presented, then a full frame.
    mode[0] = 2'd1;
    st_req[0] = 1'b1;
    for (int n = 0; n < 1000 && m_widx[0] != 31; n++) tick();
    rst_req = 1'b1;
    tick();
    tick();
    run_frame(0, 0, 16'($urandom), 1'b0);

    // Back-to-back: next start lands in the done cycle.
    run_frame(0, 1, 16'($urandom), 1'b0);
    run_frame(0, int'($urandom_range(0, 3)), 16'($urandom), 1'b1);
    run_frame(0, 0, 16'($urandom), 1'b0);
    run_frame(1, int'($urandom_range(0, 3)), 16'($urandom), 1'b1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
